// File: rtl/reg_ring_master_if.sv
// rtl/reg_ring_master_if.sv - one register-ring link (head or tail), master drives, slave receives
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

interface reg_ring_master_if #(
  parameter int SRC_W = 2
);
  logic                                req;
  logic                                ack;
  logic                                rd_wr_L;
  logic [`UDP_REG_ADDR_WIDTH-1:0]      addr;
  logic [`CPCI_NF2_DATA_WIDTH-1:0]     data;
  logic [SRC_W-1:0]                    src;

  modport master (output req, ack, rd_wr_L, addr, data, src);
  modport slave  (input  req, ack, rd_wr_L, addr, data, src);
endinterface

// File: rtl/reg_ring_master.sv
// rtl/reg_ring_master.sv - register ring head: issues one host access, waits for its return or a timeout
module reg_ring_master #(
  parameter int                           UDP_REG_SRC_WIDTH = 2,
  parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ADDR          = '0,
  parameter int                           TIMEOUT           = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               core_reg_req,
  input  logic                               core_reg_rd_wr_L,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]     core_reg_addr,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]    core_reg_wr_data,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]    core_reg_rd_data,
  output logic                               core_reg_ack,
  output logic                               core_reg_err,
  output logic [15:0]                        timeout_count,
  reg_ring_master_if.master                  ring_out,
  reg_ring_master_if.slave                   ring_in
);
  localparam int AW = `UDP_REG_ADDR_WIDTH;
  localparam int DW = `CPCI_NF2_DATA_WIDTH;
  localparam int SW = UDP_REG_SRC_WIDTH;
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [7:0]    timer_q, timer_d;
  logic [15:0]   tcnt_q, tcnt_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          req_out_q, req_out_d;
  logic          rd_wr_out_q, rd_wr_out_d;
  logic [AW-1:0] addr_out_q, addr_out_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic [SW-1:0] src_out_q, src_out_d;
  logic          ret_q, ret_d;
  logic          ret_ack_q, ret_ack_d;
  logic [DW-1:0] ret_data_q, ret_data_d;
  logic          ret_now;

  // Only our own frame arriving while waiting counts; everything else dies at the master.
  assign ret_now = (state_q == S_WAIT) && ring_in.req && (ring_in.src == SRC_ADDR);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    tcnt_d      = tcnt_q;
    rd_data_d   = rd_data_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    req_out_d   = 1'b0;
    rd_wr_out_d = rd_wr_out_q;
    addr_out_d  = addr_out_q;
    data_out_d  = data_out_q;
    src_out_d   = src_out_q;
    ret_d       = ret_now;
    ret_ack_d   = ring_in.ack;
    ret_data_d  = ring_in.data;
    case (state_q)
      S_IDLE: begin
        if (core_reg_req) begin
          req_out_d   = 1'b1;
          rd_wr_out_d = core_reg_rd_wr_L;
          addr_out_d  = core_reg_addr;
          data_out_d  = core_reg_wr_data;
          src_out_d   = SRC_ADDR;
          timer_d     = 8'd0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // A return seen in the final allowed cycle blocks the timeout and completes one cycle later.
        if (ret_q) begin
          state_d   = S_DONE;
          ack_d     = 1'b1;
          err_d     = !ret_ack_q;
          rd_data_d = ret_ack_q ? ret_data_q : DW'(32'hDEAD_BEEF);
        end else if (timer_q >= TMO && !ret_now) begin
          state_d   = S_DONE;
          ack_d     = 1'b1;
          err_d     = 1'b1;
          rd_data_d = DW'(32'hDEAD_DEAD);
          tcnt_d    = (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
        end else if (!ret_now) begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_DONE: state_d = S_HOLD;
      default: begin
        if (!core_reg_req) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      tcnt_q      <= '0;
      rd_data_q   <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      req_out_q   <= 1'b0;
      rd_wr_out_q <= 1'b0;
      addr_out_q  <= '0;
      data_out_q  <= '0;
      src_out_q   <= '0;
      ret_q       <= 1'b0;
      ret_ack_q   <= 1'b0;
      ret_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      tcnt_q      <= tcnt_d;
      rd_data_q   <= rd_data_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      req_out_q   <= req_out_d;
      rd_wr_out_q <= rd_wr_out_d;
      addr_out_q  <= addr_out_d;
      data_out_q  <= data_out_d;
      src_out_q   <= src_out_d;
      ret_q       <= ret_d;
      ret_ack_q   <= ret_ack_d;
      ret_data_q  <= ret_data_d;
    end
  end

  assign core_reg_rd_data = rd_data_q;
  assign core_reg_ack     = ack_q;
  assign core_reg_err     = err_q;
  assign timeout_count    = tcnt_q;
  assign ring_out.req     = req_out_q;
  assign ring_out.ack     = 1'b0;
  assign ring_out.rd_wr_L = rd_wr_out_q;
  assign ring_out.addr    = addr_out_q;
  assign ring_out.data    = data_out_q;
  assign ring_out.src     = src_out_q;
endmodule

// File: tb/tb_reg_ring_master.sv
// tb/tb_reg_ring_master.sv - self-checking bench for reg_ring_master
`timescale 1ns/1ps
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_reg_ring_master;
  localparam int AW  = `UDP_REG_ADDR_WIDTH;
  localparam int DW  = `CPCI_NF2_DATA_WIDTH;
  localparam int TMO = 8;
  localparam logic [1:0] SRC = 2'b01;

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            dly;
    logic          rack;
    logic [DW-1:0] rdata;
    int            fk;
    int            hold;
    int            exp_lat;
    logic [DW-1:0] exp_data;
    logic          exp_err;
    int            exp_tinc;
  } vec_t;

  logic          clk;
  logic          reset;
  logic          core_reg_req;
  logic          core_reg_rd_wr_L;
  logic [AW-1:0] core_reg_addr;
  logic [DW-1:0] core_reg_wr_data;
  logic [DW-1:0] core_reg_rd_data;
  logic          core_reg_ack;
  logic          core_reg_err;
  logic [15:0]   timeout_count;

  reg_ring_master_if #(.SRC_W(2)) ring_out ();
  reg_ring_master_if #(.SRC_W(2)) ring_in ();

  reg_ring_master #(
    .UDP_REG_SRC_WIDTH(2),
    .SRC_ADDR(SRC),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .core_reg_req(core_reg_req),
    .core_reg_rd_wr_L(core_reg_rd_wr_L),
    .core_reg_addr(core_reg_addr),
    .core_reg_wr_data(core_reg_wr_data),
    .core_reg_rd_data(core_reg_rd_data),
    .core_reg_ack(core_reg_ack),
    .core_reg_err(core_reg_err),
    .timeout_count(timeout_count),
    .ring_out(ring_out),
    .ring_in(ring_in)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_tc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic ring_idle();
    ring_in.req     = 1'b0;
    ring_in.ack     = 1'b0;
    ring_in.rd_wr_L = 1'b0;
    ring_in.addr    = '0;
    ring_in.data    = '0;
    ring_in.src     = 2'b00;
  endtask

  // Reference: a matching return in T..T+TMO completes two cycles after it; otherwise timeout at T+TMO+1.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.dly >= 0 && v.dly <= TMO) begin
      r.exp_lat  = v.dly + 2;
      r.exp_data = v.rack ? v.rdata : 32'hDEAD_BEEF;
      r.exp_err  = !v.rack;
      r.exp_tinc = 0;
    end else begin
      r.exp_lat  = TMO + 1;
      r.exp_data = 32'hDEAD_DEAD;
      r.exp_err  = 1'b1;
      r.exp_tinc = 1;
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int  t0;
    int  lat;
    bit  seen;
    bit  extra;
    core_reg_rd_wr_L = v.rd;
    core_reg_addr    = v.addr;
    core_reg_wr_data = v.wd;
    core_reg_req     = 1'b1;
    t0 = cyc;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (ring_out.req) seen = 1;
    end
    if (!seen) begin
      check({tag, " issue_seen"}, 0, 1);
      core_reg_req = 1'b0;
      tick();
      tick();
      return;
    end
    check({tag, " issue_latency"}, 64'(cyc - t0), 64'd1);
    check({tag, " issue_src"},   ring_out.src,     SRC);
    check({tag, " issue_addr"},  ring_out.addr,    v.addr);
    check({tag, " issue_rdwr"},  ring_out.rd_wr_L, v.rd);
    check({tag, " issue_data"},  ring_out.data,    v.wd);
    check({tag, " issue_ackout"}, ring_out.ack,    1'b0);
    lat = -1;
    extra = 0;
    for (int k = 0; k <= TMO + 6; k++) begin
      if (k > 0) begin
        if (ring_out.req) extra = 1;
        if (core_reg_ack) begin
          lat = k;
          break;
        end
      end
      ring_idle();
      if (k == v.dly) begin
        if (k == 0) begin
          ring_in.req     = ring_out.req;
          ring_in.ack     = ring_out.ack;
          ring_in.rd_wr_L = ring_out.rd_wr_L;
          ring_in.addr    = ring_out.addr;
          ring_in.data    = ring_out.data;
          ring_in.src     = ring_out.src;
        end else begin
          ring_in.req     = 1'b1;
          ring_in.ack     = v.rack;
          ring_in.rd_wr_L = v.rd;
          ring_in.addr    = v.addr;
          ring_in.data    = v.rdata;
          ring_in.src     = SRC;
        end
      end else if (k == v.fk) begin
        ring_in.req  = 1'b1;
        ring_in.ack  = 1'b1;
        ring_in.addr = v.addr;
        ring_in.data = 32'h5A5A_5A5A;
        ring_in.src  = 2'b11;
      end
      tick();
    end
    ring_idle();
    exp_tc = (exp_tc + v.exp_tinc > 16'hFFFF) ? 16'hFFFF : exp_tc + v.exp_tinc;
    check({tag, " ack_latency"}, 64'(lat), 64'(v.exp_lat));
    if (lat >= 0) begin
      check({tag, " rd_data"}, core_reg_rd_data, v.exp_data);
      check({tag, " err"},     core_reg_err,     v.exp_err);
      check({tag, " tcount"},  timeout_count,    16'(exp_tc));
    end
    for (int h = 0; h < v.hold; h++) begin
      tick();
      if (ring_out.req) extra = 1;
      if (h == 0) check({tag, " ack_one_cycle"}, {core_reg_ack, core_reg_err}, 2'b00);
    end
    check({tag, " no_reissue"}, extra, 1'b0);
    core_reg_req = 1'b0;
    tick();
  endtask

  vec_t tbl[5];
  vec_t rv;
  bit   bad;

  initial begin
    tbl[0] = '{rd:1'b1, addr:23'h000123, wd:32'h0, dly:1, rack:1'b1, rdata:32'h1234_5678, fk:-1, hold:1,
               exp_lat:3, exp_data:32'h1234_5678, exp_err:1'b0, exp_tinc:0};
    tbl[1] = '{rd:1'b0, addr:23'h000456, wd:32'hCAFE_0001, dly:0, rack:1'b0, rdata:32'h0, fk:-1, hold:1,
               exp_lat:2, exp_data:32'hDEAD_BEEF, exp_err:1'b1, exp_tinc:0};
    tbl[2] = '{rd:1'b1, addr:23'h012345, wd:32'h0, dly:TMO, rack:1'b1, rdata:32'h0BAD_F00D, fk:-1, hold:1,
               exp_lat:TMO+2, exp_data:32'h0BAD_F00D, exp_err:1'b0, exp_tinc:0};
    tbl[3] = '{rd:1'b1, addr:23'h000777, wd:32'h0, dly:3, rack:1'b1, rdata:32'h7777_0003, fk:1, hold:20,
               exp_lat:5, exp_data:32'h7777_0003, exp_err:1'b0, exp_tinc:0};
    tbl[4] = '{rd:1'b1, addr:23'h000999, wd:32'h0, dly:-1, rack:1'b0, rdata:32'h0, fk:-1, hold:1,
               exp_lat:TMO+1, exp_data:32'hDEAD_DEAD, exp_err:1'b1, exp_tinc:1};

    // Reset, with host and ring both active: nothing may leak out.
    reset = 1'b1;
    core_reg_req = 1'b1;
    core_reg_rd_wr_L = 1'b1;
    core_reg_addr = 23'h1;
    core_reg_wr_data = 32'h1;
    ring_idle();
    ring_in.req = 1'b1;
    ring_in.src = SRC;
    ring_in.ack = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rst_req_out",  ring_out.req, 1'b0);
    check("rst_ack_out",  ring_out.ack, 1'b0);
    check("rst_head",     {ring_out.rd_wr_L, ring_out.addr, ring_out.src}, '0);
    check("rst_head_data", ring_out.data, '0);
    check("rst_core",     {core_reg_ack, core_reg_err, timeout_count}, '0);
    check("rst_rd_data",  core_reg_rd_data, '0);
    reset = 1'b0;
    core_reg_req = 1'b0;
    ring_idle();
    tick();

    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Late return after the timeout above must be dropped.
    tick();
    ring_in.req  = 1'b1;
    ring_in.ack  = 1'b1;
    ring_in.src  = SRC;
    ring_in.data = 32'h1111_2222;
    tick();
    ring_idle();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (core_reg_ack || ring_out.req) bad = 1;
      tick();
    end
    check("late_return_dropped", bad, 1'b0);
    check("late_rd_data_held", core_reg_rd_data, 32'hDEAD_DEAD);
    check("late_tcount", timeout_count, 16'(exp_tc));

    for (int i = 0; i < 24; i++) begin
      rv.rd    = 1'($urandom_range(0, 1));
      rv.addr  = AW'($urandom);
      rv.wd    = $urandom;
      rv.dly   = $urandom_range(0, TMO + 3);
      rv.rack  = (rv.dly == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      rv.rdata = $urandom;
      rv.fk    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, TMO) : -1;
      if (rv.fk == rv.dly) rv.fk = -1;
      rv.hold  = $urandom_range(1, 3);
      rv = model(rv);
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    // Reset in WAIT: abandon, clear, ignore the return that follows.
    core_reg_req = 1'b1;
    core_reg_rd_wr_L = 1'b1;
    core_reg_addr = 23'h000ABC;
    tick();
    check("wrst_issue", ring_out.req, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    check("wrst_head_zero", {ring_out.req, ring_out.ack, ring_out.rd_wr_L, ring_out.addr, ring_out.src}, '0);
    check("wrst_core_zero", {core_reg_ack, core_reg_err, timeout_count}, '0);
    check("wrst_rd_data_zero", core_reg_rd_data, '0);
    exp_tc = 0;
    reset = 1'b0;
    core_reg_req = 1'b0;
    ring_in.req  = 1'b1;
    ring_in.ack  = 1'b1;
    ring_in.src  = SRC;
    ring_in.data = 32'h3333_4444;
    tick();
    ring_idle();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (core_reg_ack || ring_out.req) bad = 1;
      tick();
    end
    check("wrst_return_ignored", bad, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
